// File: rtl/alu_addsub_seq.sv
// Multi-cycle add/subtract unit: WIDTH-bit operation processed CHUNK bits per clock
// with a registered inter-slice carry. Define ALU_CC_EN to build the ZF/SF/OF flag logic.
module alu_addsub_seq #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int MSB    = WIDTH - 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [KW-1:0]    k;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [CHUNK:0]   slice_sum;
   logic [WIDTH-1:0] result_nxt;
   logic             accept;
   logic             last;

   // b_q already holds ~b for subtract, so the slice adder never needs op again
   always_comb begin
      accept     = start && (state != RUN);
      last       = (k == KW'(NCHUNK - 1));
      slice_sum  = {1'b0, a_q[k*CHUNK +: CHUNK]} + {1'b0, b_q[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry_q};
      result_nxt = result;
      result_nxt[k*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         k       <= '0;
         carry_q <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            k       <= '0;
            carry_q <= op;
         end else if (state == RUN) begin
            k       <= k + 1'b1;
            carry_q <= slice_sum[CHUNK];
            result  <= result_nxt;
            if (last) cout <= slice_sum[CHUNK];
         end
      end
   end

   // Operand latches carry no reset; they are only read after an accept
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= a;
         b_q <= op ? ~b : b;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

`ifdef ALU_CC_EN
   // With b_q = b' the add and subtract overflow rules collapse to one expression
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zf <= 1'b0;
         sf <= 1'b0;
         of <= 1'b0;
      end else if ((state == RUN) && last) begin
         zf <= (result_nxt == '0);
         sf <= result_nxt[MSB];
         of <= (a_q[MSB] == b_q[MSB]) && (result_nxt[MSB] != a_q[MSB]);
      end
   end
`else
   assign zf = 1'b0;
   assign sf = 1'b0;
   assign of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Bench for alu_addsub_seq: four instances (CHUNK 16, 64, 8, 1) at WIDTH 64, checked
// against table vectors, hand sequences and a plain-arithmetic reference model.
module tb_alu_addsub_seq;

   localparam int W  = 64;
   localparam int ND = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_v [ND];
   logic         op_v    [ND];
   logic [W-1:0] a_v     [ND];
   logic [W-1:0] b_v     [ND];
   logic         busy_v  [ND];
   logic         done_v  [ND];
   logic [W-1:0] res_v   [ND];
   logic         cout_v  [ND];
   logic         zf_v    [ND];
   logic         sf_v    [ND];
   logic         of_v    [ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : gen_dut
      alu_addsub_seq #(
         .WIDTH(W),
         .CHUNK((g == 0) ? 16 : (g == 1) ? 64 : (g == 2) ? 8 : 1)
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .start (start_v[g]),
         .op    (op_v[g]),
         .a     (a_v[g]),
         .b     (b_v[g]),
         .busy  (busy_v[g]),
         .done  (done_v[g]),
         .result(res_v[g]),
         .cout  (cout_v[g]),
         .zf    (zf_v[g]),
         .sf    (sf_v[g]),
         .of    (of_v[g])
      );
   end

   int n_vec = 0;
   int n_mis = 0;

   typedef struct {
      bit           op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      bit           c;
      bit           z;
      bit           s;
      bit           o;
   } vec_t;

   vec_t tbl [6];

   function automatic int nch(input int d);
      case (d)
         0:       return 4;
         1:       return 1;
         2:       return 8;
         default: return 64;
      endcase
   endfunction

   function automatic bit cc_on();
`ifdef ALU_CC_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the full operands
   task automatic model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output bit c, output bit z,
                        output bit s, output bit o);
      logic [W:0]        u;
      logic signed [W:0] sw;
      if (!op) begin
         u  = {1'b0, a} + {1'b0, b};
         r  = u[W-1:0];
         c  = u[W];
         sw = $signed({a[W-1], a}) + $signed({b[W-1], b});
      end else begin
         r  = a - b;
         c  = (a >= b);
         sw = $signed({a[W-1], a}) - $signed({b[W-1], b});
      end
      z = cc_on() && (r == '0);
      s = cc_on() && r[W-1];
      o = cc_on() && (sw[W] != sw[W-1]);
   endtask

   function automatic logic [W-1:0] rnd64();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Called at posedge+1; start is applied for one edge, then waits for done
   task automatic do_op(input int d, input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int nbusy);
      start_v[d] = 1'b1;
      op_v[d]    = op;
      a_v[d]     = a;
      b_v[d]     = b;
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      lat   = 0;
      nbusy = 0;
      while (!done_v[d] && lat < 200) begin
         if (busy_v[d]) nbusy++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_check(input int d, input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
      int           lat, nbusy;
      logic [W-1:0] r;
      bit           c, z, s, o;
      do_op(d, op, a, b, lat, nbusy);
      model(op, a, b, r, c, z, s, o);
      chk($sformatf("rnd_result d%0d", d), res_v[d], r);
      chk($sformatf("rnd_cout d%0d", d), W'(cout_v[d]), W'(c));
      chk($sformatf("rnd_zf d%0d", d), W'(zf_v[d]), W'(z));
      chk($sformatf("rnd_sf d%0d", d), W'(sf_v[d]), W'(s));
      chk($sformatf("rnd_of d%0d", d), W'(of_v[d]), W'(o));
      chk($sformatf("rnd_latency d%0d", d), W'(lat), W'(nch(d)));
      chk($sformatf("rnd_busy_cycles d%0d", d), W'(nbusy), W'(nch(d)));
   endtask

   initial begin
      int           lat, nbusy, ndone;
      logic [W-1:0] r1, r2;
      bit           c1, c2, z, s, o;

      tbl[0] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 0, 0, 0, 0};
      tbl[1] = '{1'b1, 64'h5, 64'h5, 64'h0, 1, 1, 0, 0};
      tbl[2] = '{1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0};
      tbl[3] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 0, 0, 1, 1};
      tbl[4] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0, 1};
      tbl[5] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1, 1, 0, 0};

      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) begin
         start_v[d] = 1'b0;
         op_v[d]    = 1'b0;
         a_v[d]     = '0;
         b_v[d]     = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         chk("reset_busy", W'(busy_v[d]), '0);
         chk("reset_done", W'(done_v[d]), '0);
         chk("reset_result", res_v[d], '0);
         chk("reset_flags", W'({cout_v[d], zf_v[d], sf_v[d], of_v[d]}), '0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table vectors on the CHUNK=16 instance
      for (int i = 0; i < 6; i++) begin
         do_op(0, tbl[i].op, tbl[i].a, tbl[i].b, lat, nbusy);
         chk($sformatf("tbl%0d_result", i), res_v[0], tbl[i].r);
         chk($sformatf("tbl%0d_cout", i), W'(cout_v[0]), W'(tbl[i].c));
         chk($sformatf("tbl%0d_zf", i), W'(zf_v[0]), W'(tbl[i].z && cc_on()));
         chk($sformatf("tbl%0d_sf", i), W'(sf_v[0]), W'(tbl[i].s && cc_on()));
         chk($sformatf("tbl%0d_of", i), W'(of_v[0]), W'(tbl[i].o && cc_on()));
         chk($sformatf("tbl%0d_latency", i), W'(lat), 64'd4);
         chk($sformatf("tbl%0d_busy_cycles", i), W'(nbusy), 64'd4);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_done_pulse", i), W'({busy_v[0], done_v[0]}), '0);
      end

      // Start pulses and operand changes during RUN are ignored
      start_v[0] = 1'b1; op_v[0] = 1'b0; a_v[0] = 64'd1; b_v[0] = 64'd2;
      @(posedge clk); #1;
      start_v[0] = 1'b0; a_v[0] = 64'hDEAD_BEEF; b_v[0] = 64'h1234;
      @(posedge clk); #1;
      start_v[0] = 1'b1; op_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      lat = 2;
      while (!done_v[0] && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("ignore_start_result", res_v[0], 64'd3);
      chk("ignore_start_cout", W'(cout_v[0]), '0);
      chk("ignore_start_latency", W'(lat), 64'd4);
      @(posedge clk); #1;

      // start held high through DONE: second operation follows with no IDLE cycle
      start_v[0] = 1'b1; op_v[0] = 1'b0; a_v[0] = 64'h1111_2222_3333_4444; b_v[0] = 64'hFFFF_0000_FFFF_0000;
      model(1'b0, a_v[0], b_v[0], r1, c1, z, s, o);
      @(posedge clk); #1;
      op_v[0] = 1'b1; a_v[0] = 64'h10; b_v[0] = 64'h20;
      model(1'b1, a_v[0], b_v[0], r2, c2, z, s, o);
      lat = 0;
      while (!done_v[0] && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_first_result", res_v[0], r1);
      chk("b2b_first_cout", W'(cout_v[0]), W'(c1));
      chk("b2b_first_latency", W'(lat), 64'd4);
      @(posedge clk); #1;
      chk("b2b_no_idle", W'({busy_v[0], done_v[0]}), 64'b10);
      start_v[0] = 1'b0;
      lat = 0;
      while (!done_v[0] && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_second_result", res_v[0], r2);
      chk("b2b_second_cout", W'(cout_v[0]), W'(c2));
      chk("b2b_second_sf", W'(sf_v[0]), W'(cc_on()));
      chk("b2b_second_latency", W'(lat), 64'd4);
      @(posedge clk); #1;

      // Reset during RUN aborts the operation on the CHUNK=8 instance
      start_v[2] = 1'b1; op_v[2] = 1'b1; a_v[2] = 64'h0; b_v[2] = 64'h1;
      @(posedge clk); #1;
      start_v[2] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy_done", W'({busy_v[2], done_v[2]}), '0);
      chk("abort_result", res_v[2], '0);
      chk("abort_flags", W'({cout_v[2], zf_v[2], sf_v[2], of_v[2]}), '0);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done_v[2] || busy_v[2]) ndone++;
      end
      chk("abort_no_done", W'(ndone), '0);

      // Random sweep over all chunk sizes
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 20; i++) begin
            run_check(d, 1'($urandom_range(0, 1)), rnd64(), rnd64());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
